// File: rtl/player_motion.sv
// Overworld player position engine: per-frame WASD motion, edge/boulder blocking, encounter roll.
// Define PLAYER_COLLIDE_EN to enable the boulder rectangle checks; otherwise only screen edges block.
module player_motion #(
    parameter int unsigned STEP       = 2,
    parameter int unsigned START_X    = 100,
    parameter int unsigned START_Y    = 100,
    parameter logic [7:0]  ENC_THRESH = 8'd24,
    parameter int unsigned BUMP_FRMS  = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       enable,
    input  logic [7:0] keycode,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [1:0] facing,
    output logic [1:0] walk_frame,
    output logic       encounter
);

    localparam logic [9:0] StepV  = 10'(STEP);
    localparam logic [9:0] MaxX   = 10'd626;
    localparam logic [9:0] MaxY   = 10'd460;
    localparam logic [7:0] KeyW   = 8'h1A;
    localparam logic [7:0] KeyS   = 8'h16;
    localparam logic [7:0] KeyA   = 8'h04;
    localparam logic [7:0] KeyD   = 8'h07;
    localparam logic [7:0] KeyEnt = 8'h28;
    localparam int unsigned BumpW = $clog2(BUMP_FRMS + 1);
    localparam logic [BumpW-1:0] BumpLast = BumpW'(BUMP_FRMS - 1);

    typedef enum logic [1:0] {StIdle, StMove, StBump, StEnc} state_e;

    state_e           state_q, state_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic [1:0]       facing_q, facing_d;
    logic [1:0]       walk_q, walk_d, div_q, div_d;
    logic [5:0]       step_q, step_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [BumpW-1:0] bump_q, bump_d;
    logic             sync1_q, sync2_q, prev_q;

    logic       tick, dir_valid, hit, blocked, commit, tile_done;
    logic [1:0] dir_face;
    logic [9:0] cand_x, cand_y;
    logic [5:0] step_sum, step_next;

    assign tick = sync2_q & ~prev_q;

    always_comb begin
        dir_valid = 1'b1;
        dir_face  = 2'b00;
        case (keycode)
            KeyW:    dir_face = 2'b01;
            KeyS:    dir_face = 2'b00;
            KeyA:    dir_face = 2'b10;
            KeyD:    dir_face = 2'b11;
            default: dir_valid = 1'b0;
        endcase
    end

    // Saturating candidate; a saturated no-op move counts as blocked below.
    always_comb begin
        cand_x = x_q;
        cand_y = y_q;
        case (dir_face)
            2'b00: cand_y = (y_q + StepV > MaxY) ? MaxY : y_q + StepV;
            2'b01: cand_y = (y_q >= StepV) ? y_q - StepV : 10'd0;
            2'b10: cand_x = (x_q >= StepV) ? x_q - StepV : 10'd0;
            2'b11: cand_x = (x_q + StepV > MaxX) ? MaxX : x_q + StepV;
        endcase
    end

`ifdef PLAYER_COLLIDE_EN
    function automatic logic overlaps(input logic [9:0] cx, input logic [9:0] cy,
                                      input logic [9:0] x0, input logic [9:0] x1,
                                      input logic [9:0] y0, input logic [9:0] y1);
        return (cx <= x1) && ((cx + 10'd13) >= x0) && (cy <= y1) && ((cy + 10'd19) >= y0);
    endfunction

    always_comb begin
        hit = overlaps(cand_x, cand_y, 10'd0,   10'd399, 10'd60,  10'd78)  |
              overlaps(cand_x, cand_y, 10'd500, 10'd639, 10'd200, 10'd218) |
              overlaps(cand_x, cand_y, 10'd0,   10'd299, 10'd300, 10'd318) |
              overlaps(cand_x, cand_y, 10'd440, 10'd458, 10'd340, 10'd398) |
              overlaps(cand_x, cand_y, 10'd440, 10'd639, 10'd399, 10'd418);
    end
`else
    always_comb begin
        hit = 1'b0;
    end
`endif

    assign blocked   = ((cand_x == x_q) && (cand_y == y_q)) | hit;
    assign step_sum  = step_q + 6'(STEP);
    assign tile_done = (step_sum >= 6'd20);
    assign step_next = tile_done ? step_sum - 6'd20 : step_sum;
    assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        facing_d = facing_q;
        walk_d   = walk_q;
        div_d    = div_q;
        step_d   = step_q;
        bump_d   = bump_q;
        commit   = 1'b0;
        case (state_q)
            StIdle: begin
                if (tick && enable && dir_valid) begin
                    facing_d = dir_face;
                    if (blocked) begin
                        state_d = StBump;
                        bump_d  = '0;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            StMove: begin
                if (tick && enable) begin
                    if (!dir_valid) begin
                        state_d = StIdle;
                        walk_d  = 2'd0;
                        div_d   = 2'd0;
                    end else begin
                        facing_d = dir_face;
                        if (blocked) begin
                            state_d = StBump;
                            bump_d  = '0;
                        end else begin
                            commit = 1'b1;
                        end
                    end
                end
            end
            StBump: begin
                if (tick && enable) begin
                    if (bump_q == BumpLast) begin
                        state_d = StIdle;
                        walk_d  = 2'd0;
                        div_d   = 2'd0;
                    end else begin
                        bump_d = bump_q + 1'b1;
                    end
                end
            end
            StEnc: begin
                if (keycode == KeyEnt) begin
                    state_d = StIdle;
                    walk_d  = 2'd0;
                    div_d   = 2'd0;
                end
            end
        endcase
        if (commit) begin
            x_d    = cand_x;
            y_d    = cand_y;
            step_d = step_next;
            div_d  = div_q + 1'b1;
            if (div_q == 2'd3) walk_d = walk_q + 1'b1;
            state_d = (tile_done && (lfsr_q < ENC_THRESH)) ? StEnc : StMove;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= StIdle;
            x_q      <= 10'(START_X);
            y_q      <= 10'(START_Y);
            facing_q <= 2'b00;
            walk_q   <= 2'd0;
            div_q    <= 2'd0;
            step_q   <= 6'd0;
            bump_q   <= '0;
            lfsr_q   <= 8'hA5;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            facing_q <= facing_d;
            walk_q   <= walk_d;
            div_q    <= div_d;
            step_q   <= step_d;
            bump_q   <= bump_d;
            lfsr_q   <= lfsr_d;
            sync1_q  <= frame_clk;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
        end
    end

    assign BallX      = x_q;
    assign BallY      = y_q;
    assign facing     = facing_q;
    assign walk_frame = walk_q;
    assign encounter  = (state_q == StEnc);

endmodule

// File: tb/tb_player_motion.sv
// Randomized bench for player_motion against a per-frame behavioural model of the player.
// Honours PLAYER_COLLIDE_EN the same way the design does.
module tb_player_motion;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       enable;
    logic [7:0] keycode;
    logic [9:0] BallX, BallY;
    logic [1:0] facing, walk_frame;
    logic       encounter;

    player_motion dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .enable     (enable),
        .keycode    (keycode),
        .BallX      (BallX),
        .BallY      (BallY),
        .facing     (facing),
        .walk_frame (walk_frame),
        .encounter  (encounter)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    localparam int MIdle = 0, MMove = 1, MBump = 2, MEnc = 3;

    int n_checks = 0;
    int n_fail   = 0;

    int m_x, m_y, m_face, m_moves, m_steps, m_state, m_bump_left;
    logic [7:0] m_lfsr;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        logic [7:0] t;
        t = v & 8'hB8;
        return {v[6:0], ^t};
    endfunction

    // Free-running reference LFSR: polynomial x^8+x^6+x^5+x^4+1, seed A5, steps every Clk.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

`ifdef PLAYER_COLLIDE_EN
    localparam int RX0 [5] = '{0, 500, 0, 440, 440};
    localparam int RX1 [5] = '{399, 639, 299, 458, 639};
    localparam int RY0 [5] = '{60, 200, 300, 340, 399};
    localparam int RY1 [5] = '{78, 218, 318, 398, 418};
`endif

    function automatic bit hits_boulder(input int x, input int y);
`ifdef PLAYER_COLLIDE_EN
        for (int i = 0; i < 5; i++) begin
            if (x <= RX1[i] && x + 13 >= RX0[i] && y <= RY1[i] && y + 19 >= RY0[i]) return 1'b1;
        end
`endif
        return (x < 0) && (y < 0);
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 100; m_y = 100; m_face = 0; m_moves = 0; m_steps = 0;
        m_state = MIdle; m_bump_left = 0;
    endtask

    task automatic apply_enter();
        if (m_state == MEnc && keycode == 8'h28) begin
            m_state = MIdle;
            m_moves = 0;
        end
    endtask

    task automatic model_tick(input logic [7:0] key, input logic en, input logic [7:0] lf);
        int nx, ny, face;
        bit dir;
        if (!en || m_state == MEnc) return;
        if (m_state == MBump) begin
            m_bump_left--;
            if (m_bump_left == 0) begin
                m_state = MIdle;
                m_moves = 0;
            end
            return;
        end
        nx = m_x; ny = m_y; dir = 1'b1; face = 0;
        case (key)
            8'h1A: begin face = 1; ny = m_y - 2; if (ny < 0) ny = 0; end
            8'h16: begin face = 0; ny = m_y + 2; if (ny > 460) ny = 460; end
            8'h04: begin face = 2; nx = m_x - 2; if (nx < 0) nx = 0; end
            8'h07: begin face = 3; nx = m_x + 2; if (nx > 626) nx = 626; end
            default: dir = 1'b0;
        endcase
        if (!dir) begin
            if (m_state == MMove) begin
                m_state = MIdle;
                m_moves = 0;
            end
            return;
        end
        m_face = face;
        if ((nx == m_x && ny == m_y) || hits_boulder(nx, ny)) begin
            m_state = MBump;
            m_bump_left = 8;
            return;
        end
        m_x = nx; m_y = ny; m_moves++; m_steps += 2;
        m_state = MMove;
        if (m_steps >= 20) begin
            m_steps -= 20;
            if (lf < 8'd24) m_state = MEnc;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_x"}, int'(BallX), m_x);
        check_eq({tag, "_y"}, int'(BallY), m_y);
        check_eq({tag, "_facing"}, int'(facing), m_face);
        check_eq({tag, "_walk"}, int'(walk_frame), (m_moves / 4) % 4);
        check_eq({tag, "_enc"}, int'(encounter), (m_state == MEnc) ? 1 : 0);
    endtask

    // One frame pulse; wait_low delays the edge until the LFSR seen at the tick is below 24.
    task automatic do_tick(input bit wait_low);
        int guard;
        guard = 0;
        @(negedge Clk);
        while (wait_low && lfsr_step(lfsr_step(m_lfsr)) >= 8'd24 && guard < 1000) begin
            @(negedge Clk);
            guard++;
        end
        if (wait_low) check_eq("lfsr_wait_bound", (guard < 1000) ? 1 : 0, 1);
        frame_clk = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        check_eq("pre_tick_x", int'(BallX), m_x);
        check_eq("pre_tick_y", int'(BallY), m_y);
        @(posedge Clk);
        model_tick(keycode, enable, m_lfsr);
        apply_enter();
        @(negedge Clk);
        frame_clk = 1'b0;
        check_eq("lat_x", int'(BallX), m_x);
        check_eq("lat_y", int'(BallY), m_y);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_all("tick");
    endtask

    task automatic set_key(input logic [7:0] k);
        @(negedge Clk);
        keycode = k;
        apply_enter();
    endtask

    task automatic run_key(input logic [7:0] k, input int n, input bit auto_clear);
        set_key(k);
        for (int i = 0; i < n; i++) begin
            if (auto_clear && m_state == MEnc) begin
                set_key(8'h28);
                set_key(k);
            end
            do_tick(1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        #1;
        check_eq("rst_x", int'(BallX), 100);
        check_eq("rst_y", int'(BallY), 100);
        check_eq("rst_facing", int'(facing), 0);
        check_eq("rst_walk", int'(walk_frame), 0);
        check_eq("rst_enc", int'(encounter), 0);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    logic [7:0] keys [7] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h00, 8'h28, 8'h55};

    initial begin
        Reset = 1'b1;
        frame_clk = 1'b0;
        enable = 1'b1;
        keycode = 8'h00;
        model_reset();
        #2 Reset = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        check_all("reset");

        // Walk right ten frames from the start position.
        run_key(8'h07, 10, 1'b1);
        check_eq("t2_x", int'(BallX), 120);
        check_eq("t2_y", int'(BallY), 100);
        check_eq("t2_facing", int'(facing), 3);
        check_eq("t2_walk", int'(walk_frame), 2);

        // Reset while moving.
        run_key(8'h07, 1, 1'b1);
        do_reset();

        // Walk up: boulder row stops at 80, otherwise the top edge at 0.
        run_key(8'h1A, 60, 1'b1);
        check_eq("t3_x", int'(BallX), 100);
`ifdef PLAYER_COLLIDE_EN
        check_eq("t3_y", int'(BallY), 80);
`else
        check_eq("t3_y", int'(BallY), 0);
`endif
        check_eq("t3_facing", int'(facing), 1);

        // Left edge: no wrap.
        run_key(8'h04, 70, 1'b1);
        check_eq("t4_x", int'(BallX), 0);
        run_key(8'h04, 3, 1'b1);
        check_eq("t4_x_hold", int'(BallX), 0);

        // Encounter on the tenth move, frozen until Enter.
        do_reset();
        run_key(8'h16, 9, 1'b0);
        do_tick(1'b1);
        check_eq("t5_enc", int'(encounter), 1);
        check_eq("t5_y", int'(BallY), 120);
        do_tick(1'b0);
        check_eq("t5_frozen_y", int'(BallY), 120);
        check_eq("t5_enc_hold", int'(encounter), 1);
        set_key(8'h28);
        @(negedge Clk);
        check_eq("t5_enc_clr", int'(encounter), 0);
        run_key(8'h16, 1, 1'b0);
        check_eq("t5_resume_y", int'(BallY), 122);

        // enable low freezes motion.
        do_reset();
        enable = 1'b0;
        run_key(8'h16, 5, 1'b0);
        check_eq("t6_x", int'(BallX), 100);
        check_eq("t6_y", int'(BallY), 100);
        enable = 1'b1;
        do_tick(1'b0);
        check_eq("t6_resume_y", int'(BallY), 102);

        // Random traffic.
        for (int r = 0; r < 60; r++) begin
            int n;
            enable = ($urandom_range(0, 9) != 0);
            set_key(keys[$urandom_range(0, 6)]);
            n = $urandom_range(1, 12);
            for (int j = 0; j < n; j++) do_tick($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 29) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
